// File: rtl/instr_pkg.sv
// Shared widths, buffer state encoding and counter width for the instruction decode stage.
package instr_pkg;

    localparam int INSTR_W_DEF = 14;
    localparam int FLAG_W_DEF  = 3;
    localparam int D_W_DEF     = INSTR_W_DEF - FLAG_W_DEF;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/instr_decode_if.sv
// Upstream handshake, flush and decoded output bundle of the instruction decode stage.
interface instr_decode_if
    import instr_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int FLAG_W  = FLAG_W_DEF
);
    localparam int D_W = INSTR_W - FLAG_W;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [D_W-1:0]     out_d;
    logic [FLAG_W-1:0]  out_flags;

    // master: program memory + control unit side; slave: the decode stage
    modport master (
        output flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_instr, out_d, out_flags
    );

    modport slave (
        input  flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_instr, out_d, out_flags
    );

endinterface

// File: rtl/instr_field_split.sv
// Pure wiring split of an instruction word into operand field and per-bit flags.
module instr_field_split #(
    parameter int INSTR_W = 14,
    parameter int FLAG_W  = 3
) (
    input  logic [INSTR_W-1:0]        instr,
    output logic [INSTR_W-FLAG_W-1:0] d,
    output logic [FLAG_W-1:0]         flags
);
    localparam int D_W = INSTR_W - FLAG_W;

    assign d = instr[D_W-1:0];

    // flags[i] is instruction bit D_W+i
    for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_flag
        assign flags[gi] = instr[D_W+gi];
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Two-entry skid-buffered instruction register feeding the control unit.
// Optional output-beat counter port instr_count when INSTR_DECODE_COUNT_EN is defined.
module instr_decode_stage
    import instr_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int FLAG_W  = FLAG_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    instr_decode_if.slave   bus
`ifdef INSTR_DECODE_COUNT_EN
    ,
    output logic [CNT_W-1:0] instr_count
`endif
);
    state_e             state_q, state_d;
    logic [INSTR_W-1:0] main_q, main_d;
    logic [INSTR_W-1:0] skid_q, skid_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               in_beat;
    logic               out_beat;

    assign in_beat  = bus.in_valid & in_ready_q;
    assign out_beat = out_valid_q & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_beat) begin
                    main_d  = bus.in_instr;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_beat && out_beat) begin
                    main_d = bus.in_instr;
                end else if (in_beat) begin
                    skid_d  = bus.in_instr;
                    state_d = ST_TWO;
                end else if (out_beat) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_beat) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins: any word accepted this cycle is dropped, main keeps its
        // last contents so out_instr does not glitch while invalid.
        if (bus.flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_instr = main_q;

    instr_field_split #(
        .INSTR_W (INSTR_W),
        .FLAG_W  (FLAG_W)
    ) u_split (
        .instr (main_q),
        .d     (bus.out_d),
        .flags (bus.out_flags)
    );

`ifdef INSTR_DECODE_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    // Counts consumed words, including one consumed in a flush cycle; wraps naturally.
    always_comb begin
        count_d = count_q + CNT_W'(out_beat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;
`endif

endmodule
